// File: rtl/gpio_pkg.sv
// gpio_pkg: constants shared by the GPIO peripheral, its input conditioner and their benches
//   GPIO_WIDTH   default pin count
//   REG_*        peripheral register byte offsets
//   clog2_min1   counter width helper that never returns 0
package gpio_pkg;
   localparam int GPIO_WIDTH = 32;
   localparam logic [7:0] REG_OUT      = 8'h00;
   localparam logic [7:0] REG_OE       = 8'h04;
   localparam logic [7:0] REG_IN       = 8'h08;
   localparam logic [7:0] REG_INT_EN   = 8'h0C;
   localparam logic [7:0] REG_INT_STAT = 8'h10;
   localparam logic [7:0] REG_INT_CLR  = 8'h14;
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/gpio_in_conditioner_if.sv
// gpio_in_conditioner_if: pad-side and peripheral-side signals of the input conditioner
//   pad_in, bypass             raw pad levels and per-pin debounce bypass (into the conditioner)
//   gpio_in, rise/fall_pulse   conditioned levels and edge strobes (out of the conditioner)
//   sample_tick                debounce sample strobe (out of the conditioner)
interface gpio_in_conditioner_if import gpio_pkg::*; #(parameter int WIDTH = GPIO_WIDTH) ();
   logic [WIDTH-1:0] pad_in;
   logic [WIDTH-1:0] bypass;
   logic [WIDTH-1:0] gpio_in;
   logic [WIDTH-1:0] rise_pulse;
   logic [WIDTH-1:0] fall_pulse;
   logic             sample_tick;
   modport slave (input pad_in, bypass, output gpio_in, rise_pulse, fall_pulse, sample_tick);
   modport master (output pad_in, bypass, input gpio_in, rise_pulse, fall_pulse, sample_tick);
endinterface

// File: rtl/gpio_debounce_cell.sv
// gpio_debounce_cell: one pin of synchroniser, tick-sampled debounce filter and edge detector
//   clk, rst   clock, asynchronous active-high reset
//   i_pad      raw asynchronous pad level
//   i_bypass   1 = output follows the synchronised level every cycle
//   i_tick     shared debounce sample strobe
//   o_gpio     conditioned stable level
//   o_rise     1-cycle pulse the cycle after o_gpio goes 0->1
//   o_fall     1-cycle pulse the cycle after o_gpio goes 1->0
module gpio_debounce_cell import gpio_pkg::*; #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_COUNT    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pad,
   input  logic i_bypass,
   input  logic i_tick,
   output logic o_gpio,
   output logic o_rise,
   output logic o_fall
);
   localparam int CW = $clog2(DB_COUNT + 1);
   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic [CW-1:0]          w_cnt_nx;
   logic                   r_gpio;
   logic                   r_gpio_d;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_sync;
   logic                   w_gpio_nx;
   logic                   w_diff;
   logic                   w_accept;
   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign w_diff   = w_sync != r_gpio;
   assign w_accept = w_diff && (r_cnt == CW'(DB_COUNT - 1));
   // counter only tracks an unbroken run of differing samples; one matching sample restarts it
   always_comb begin
      w_cnt_nx  = r_cnt;
      w_gpio_nx = r_gpio;
      if (i_bypass) begin
         w_cnt_nx  = '0;
         w_gpio_nx = w_sync;
      end else if (i_tick) begin
         w_cnt_nx  = (!w_diff || w_accept) ? '0 : r_cnt + 1'b1;
         w_gpio_nx = w_accept ? w_sync : r_gpio;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync   <= '0;
         r_cnt    <= '0;
         r_gpio   <= 1'b0;
         r_gpio_d <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], i_pad};
         r_cnt    <= w_cnt_nx;
         r_gpio   <= w_gpio_nx;
         r_gpio_d <= r_gpio;
         r_rise   <= r_gpio & ~r_gpio_d;
         r_fall   <= ~r_gpio & r_gpio_d;
      end
   end
   assign o_gpio = r_gpio;
   assign o_rise = r_rise;
   assign o_fall = r_fall;
endmodule

// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: pad synchronise, debounce and edge-detect front end for the GPIO peripheral
//   clk, rst   clock, asynchronous active-high reset
//   io         slave side of gpio_in_conditioner_if (pad_in, bypass in; gpio_in, pulses, tick out)
module gpio_in_conditioner import gpio_pkg::*; #(
   parameter int WIDTH       = GPIO_WIDTH,
   parameter int SYNC_STAGES = 2,
   parameter int PRESCALE    = 1000,
   parameter int DB_COUNT    = 4
) (
   input logic                  clk,
   input logic                  rst,
   gpio_in_conditioner_if.slave io
);
   localparam int PW = clog2_min1(PRESCALE);
   logic [PW-1:0]    r_pcnt;
   logic             r_tick;
   logic             w_wrap;
   logic [WIDTH-1:0] w_gpio;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   assign w_wrap = r_pcnt == PW'(PRESCALE - 1);
   // with PRESCALE=1 the counter sits at 0, so the tick stays high every cycle after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pcnt <= '0;
         r_tick <= 1'b0;
      end else begin
         r_pcnt <= w_wrap ? '0 : r_pcnt + 1'b1;
         r_tick <= w_wrap;
      end
   end
   for (genvar g = 0; g < WIDTH; g++) begin : g_pin
      gpio_debounce_cell #(
         .SYNC_STAGES (SYNC_STAGES),
         .DB_COUNT    (DB_COUNT)
      ) u_cell (
         .clk      (clk),
         .rst      (rst),
         .i_pad    (io.pad_in[g]),
         .i_bypass (io.bypass[g]),
         .i_tick   (r_tick),
         .o_gpio   (w_gpio[g]),
         .o_rise   (w_rise[g]),
         .o_fall   (w_fall[g])
      );
   end
   assign io.gpio_in     = w_gpio;
   assign io.rise_pulse  = w_rise;
   assign io.fall_pulse  = w_fall;
   assign io.sample_tick = r_tick;
endmodule
